// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the BRAM port-A byte sequencer.
package mem_pkg;

  localparam int unsigned MEM_BYTES_DEF = 425984;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_LAST = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // Byte count of an access; the illegal encoding maps to 4 but is rejected anyway.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Zero/sign extension of the assembled little-endian load bytes.
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  always_comb begin
    case (size)
      SIZE_B:  result = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_H:  result = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_port_sched.sv
// Port-A arbiter/sequencer: shares the 8-bit BRAM port between instruction
// fetch and load/store, serialising each access into byte cycles.
module mem_port_sched
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
  parameter logic        DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [18:0] if_addr,
  output logic        if_ready,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [18:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_err,
  output logic [31:0] rdata,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wd,
  input  logic [7:0]  mem_rd
);

  state_t      state;
  logic        gnt_d;
  logic        st_uns;
  logic [1:0]  st_size;
  logic [18:0] base;
  logic [31:0] wdata_q;
  logic [31:0] raw_q;
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [18:0] addr_q;

  logic        pick_d;
  logic        pick_any;
  logic [1:0]  sel_size;
  logic [18:0] sel_addr;
  logic        sel_we;
  logic [2:0]  sel_n;
  logic [19:0] sel_end;
  logic        sel_bad;

  logic [31:0] raw_next;
  logic [31:0] ext_word;
  logic [31:0] wd_shift;

  // Arbitration and error screening of the request presented in IDLE.
  always_comb begin
    pick_d   = d_req && (DATA_FIRST || !if_req);
    pick_any = d_req || if_req;
    sel_size = pick_d ? d_size : SIZE_W;
    sel_addr = pick_d ? d_addr : if_addr;
    sel_we   = pick_d && d_we;
    sel_n    = byte_count(sel_size);
    sel_end  = {1'b0, sel_addr} + {17'b0, sel_n};
    sel_bad  = (sel_size == 2'b11)
            || ((sel_size == SIZE_H) && sel_addr[0])
            || ((sel_size == SIZE_W) && (sel_addr[1:0] != 2'b00))
            || (32'(sel_end) > MEM_BYTES);
  end

  always_comb begin
    wd_shift = wdata_q >> {cnt, 3'b000};
    mem_we   = 1'b0;
    mem_wd   = '0;
    mem_addr = addr_q;
    case (state)
      ST_RD:      mem_addr = base + {17'b0, cnt};
      ST_RD_LAST: mem_addr = base + {17'b0, last};
      ST_WR: begin
        mem_we   = 1'b1;
        mem_addr = base + {17'b0, cnt};
        mem_wd   = wd_shift[7:0];
      end
      default: ;
    endcase
  end

  // The final byte arrives in RD_LAST and is merged straight into the
  // extension path so rdata is already valid during the ready pulse.
  always_comb begin
    raw_next = raw_q;
    raw_next[{last, 3'b000} +: 8] = mem_rd;
  end

  load_ext u_ext (
    .raw         (raw_next),
    .size        (st_size),
    .is_unsigned (st_uns),
    .result      (ext_word)
  );

  assign if_ready = (state == ST_DONE) && !gnt_d;
  assign d_ready  = (state == ST_DONE) &&  gnt_d;
  assign if_err   = (state == ST_ERR)  && !gnt_d;
  assign d_err    = (state == ST_ERR)  &&  gnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt_d   <= 1'b0;
      st_uns  <= 1'b0;
      st_size <= SIZE_W;
      base    <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
      cnt     <= '0;
      last    <= '0;
      addr_q  <= '0;
      rdata   <= '0;
    end else begin
      addr_q <= mem_addr;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_d   <= pick_d;
            st_size <= sel_size;
            st_uns  <= pick_d ? d_unsigned : 1'b1;
            base    <= sel_addr;
            wdata_q <= d_wdata;
            last    <= 2'(sel_n - 3'd1);
            cnt     <= '0;
            if (sel_bad)     state <= ST_ERR;
            else if (sel_we) state <= ST_WR;
            else             state <= ST_RD;
          end
        end
        ST_RD: begin
          if (cnt != 2'd0) raw_q[{cnt - 2'd1, 3'b000} +: 8] <= mem_rd;
          if (cnt == last) state <= ST_RD_LAST;
          else             cnt   <= cnt + 2'd1;
        end
        ST_RD_LAST: begin
          raw_q <= raw_next;
          rdata <= ext_word;
          state <= ST_DONE;
        end
        ST_WR: begin
          if (cnt == last) state <= ST_DONE;
          else             cnt   <= cnt + 2'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched with a behavioural byte BRAM and a response scoreboard.
module tb_mem_port_sched;
  import mem_pkg::*;

  localparam int unsigned MB = 425984;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [18:0] if_addr;
  logic        if_ready, if_err;
  logic        d_req, d_we, d_unsigned;
  logic [1:0]  d_size;
  logic [18:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready, d_err;
  logic [31:0] rdata;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  always #5 clk = ~clk;

  mem_port_sched #(.MEM_BYTES(MB), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_err(d_err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  logic [7:0]  mem [0:MB-1];
  int unsigned we_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wd;
      we_cnt <= we_cnt + 1;
    end
    mem_rd <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_fetch;
    logic        is_err;
    logic [31:0] data;
    logic        chk_data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input string tag, input int n, input int t0);
    int   got;
    exp_t e;
    logic [3:0] want;
    got = 0;
    for (int k = 0; k < 40 && got < n; k++) begin
      @(negedge clk);
      if (if_ready || if_err || d_ready || d_err) begin
        if (sb.size() == 0) begin
          check({tag, " extra"}, 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          want = e.is_fetch ? (e.is_err ? 4'b0100 : 4'b1000)
                            : (e.is_err ? 4'b0001 : 4'b0010);
          check({tag, " who"}, 64'({if_ready, if_err, d_ready, d_err}), 64'(want));
          check({tag, " lat"}, 64'(cyc - t0), 64'(e.lat));
          if (e.chk_data) check({tag, " rdata"}, 64'(rdata), 64'(e.data));
        end
        if (if_ready || if_err) if_req = 1'b0;
        if (d_ready || d_err)   d_req  = 1'b0;
        got++;
      end
    end
    if (got < n) check({tag, " timeout"}, 64'(got), 64'(n));
  endtask

  task automatic d_txn(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [18:0] addr, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_data, input int e_lat);
    int t0;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wd;
    t0 = cyc;
    sb.push_back('{1'b0, e_err, e_data, !we && !e_err, e_lat});
    collect(tag, 1, t0);
  endtask

  task automatic f_txn(input string tag, input logic [18:0] addr,
                       input logic e_err, input logic [31:0] e_data, input int e_lat);
    int t0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    t0 = cyc;
    sb.push_back('{1'b1, e_err, e_data, !e_err, e_lat});
    collect(tag, 1, t0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned we0;
    logic [18:0] a0;
    int t0;

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = SIZE_W; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset outs", 64'({if_ready, if_err, d_ready, d_err, mem_we, mem_wd, mem_addr, rdata}), 64'(0));

    // Word store, then read it back
    we0 = we_cnt;
    d_txn("st w100", 1'b1, SIZE_W, 1'b0, 19'h00100, 32'hDEADBEEF, 1'b0, 32'h0, 5);
    check("st w100 wecnt", 64'(we_cnt - we0), 64'(4));
    check("st w100 bytes", 64'({mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]}), 64'(32'hDEADBEEF));
    d_txn("ld w100", 1'b0, SIZE_W, 1'b0, 19'h00100, 32'h0, 1'b0, 32'hDEADBEEF, 6);

    // Byte and half extension
    d_txn("st b205", 1'b1, SIZE_B, 1'b0, 19'h00205, 32'h12345680, 1'b0, 32'h0, 2);
    check("st b205 mem", 64'(mem[32'h205]), 64'(8'h80));
    d_txn("ld b205 s", 1'b0, SIZE_B, 1'b0, 19'h00205, 32'h0, 1'b0, 32'hFFFFFF80, 3);
    d_txn("ld b205 u", 1'b0, SIZE_B, 1'b1, 19'h00205, 32'h0, 1'b0, 32'h00000080, 3);
    d_txn("st h300", 1'b1, SIZE_H, 1'b0, 19'h00300, 32'hABCD8001, 1'b0, 32'h0, 3);
    d_txn("ld h300 s", 1'b0, SIZE_H, 1'b0, 19'h00300, 32'h0, 1'b0, 32'hFFFF8001, 4);
    d_txn("ld h300 u", 1'b0, SIZE_H, 1'b1, 19'h00300, 32'h0, 1'b0, 32'h00008001, 4);

    // Simultaneous fetch and data load: data wins, fetch follows after one IDLE
    d_txn("st w000", 1'b1, SIZE_W, 1'b0, 19'h00000, 32'h00000513, 1'b0, 32'h0, 5);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = SIZE_W; d_unsigned = 1'b0; d_addr = 19'h00100;
    if_req = 1'b1; if_addr = 19'h00000;
    t0 = cyc;
    sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 6});
    sb.push_back('{1'b1, 1'b0, 32'h00000513, 1'b1, 13});
    collect("arb", 2, t0);

    // Error cases: no memory activity, address bus untouched
    we0 = we_cnt; a0 = mem_addr;
    d_txn("err w102", 1'b0, SIZE_W, 1'b0, 19'h00102, 32'h0, 1'b1, 32'h0, 1);
    f_txn("err f68000", 19'h68000, 1'b1, 32'h0, 1);
    d_txn("err h301", 1'b1, SIZE_H, 1'b0, 19'h00301, 32'h0, 1'b1, 32'h0, 1);
    d_txn("err sz11", 1'b0, 2'b11, 1'b0, 19'h00100, 32'h0, 1'b1, 32'h0, 1);
    d_txn("err b68000", 1'b0, SIZE_B, 1'b0, 19'h68000, 32'h0, 1'b1, 32'h0, 1);
    check("err wecnt", 64'(we_cnt - we0), 64'(0));
    check("err addr", 64'(mem_addr), 64'(a0));

    // Reset in the middle of a word store
    d_txn("st w400", 1'b1, SIZE_W, 1'b0, 19'h00400, 32'h11223344, 1'b0, 32'h0, 5);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = SIZE_W; d_addr = 19'h00400; d_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("rst we", 64'({mem_we, d_ready, d_err}), 64'(0));
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst no resp", 64'({d_ready, d_err, mem_we}), 64'(0));
    end
    check("rst bytes", 64'({mem[32'h403], mem[32'h402], mem[32'h401], mem[32'h400]}), 64'(32'h1122CCDD));
    d_txn("ld w400", 1'b0, SIZE_W, 1'b0, 19'h00400, 32'h0, 1'b0, 32'h1122CCDD, 6);

    // Adjacent 2 KiB blocks
    d_txn("st w7fc", 1'b1, SIZE_W, 1'b0, 19'h007FC, 32'hCAFEF00D, 1'b0, 32'h0, 5);
    d_txn("st w800", 1'b1, SIZE_W, 1'b0, 19'h00800, 32'h0BADC0DE, 1'b0, 32'h0, 5);
    d_txn("ld w7fc", 1'b0, SIZE_W, 1'b0, 19'h007FC, 32'h0, 1'b0, 32'hCAFEF00D, 6);
    d_txn("ld w800", 1'b0, SIZE_W, 1'b0, 19'h00800, 32'h0, 1'b0, 32'h0BADC0DE, 6);
    f_txn("f w800", 19'h00800, 1'b0, 32'h0BADC0DE, 6);

    check("sb empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
